// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the 12-bit renderer colour type.
// The generator's parameters default to these values; smaller modes can override them.
package vga_pkg;

    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BP    = 33;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int COLOR_W     = 12;
    localparam int COLOR_R_LSB = 0;
    localparam int COLOR_G_LSB = 4;
    localparam int COLOR_B_LSB = 8;

    // Field order puts blue in [11:8], green in [7:4] and red in [3:0].
    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic [3:0] r;
    } color_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel bus between the timing generator (master) and the renderer/DAC side (slave).
interface vga_timing_gen_if
    import vga_pkg::*;
;
    color_t     pixel_color;
    logic [9:0] X_pix;
    logic [9:0] Y_pix;
    logic       H_visible;
    logic       V_visible;
    logic       pixel_clk;
    logic       frame_tick;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;

    modport master (
        input  pixel_color,
        output X_pix, Y_pix, H_visible, V_visible, pixel_clk, frame_tick,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

    modport slave (
        output pixel_color,
        input  X_pix, Y_pix, H_visible, V_visible, pixel_clk, frame_tick,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: a wrapping position counter with registered visible flag,
// a combinational sync-window compare and a wrap strobe that chains to the next axis.
module vga_axis_counter #(
    parameter int VIS  = 640,
    parameter int FP   = 16,
    parameter int SYNC = 96
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [9:0] tc_i,
    output logic [9:0] count_o,
    output logic       visible_o,
    output logic       sync_o,
    output logic       wrap_o
);

    localparam logic [9:0] VIS_END    = 10'(VIS);
    localparam logic [9:0] SYNC_FIRST = 10'(VIS + FP);
    localparam logic [9:0] SYNC_LAST  = 10'(VIS + FP + SYNC - 1);

    logic [9:0] count_q, count_d;
    logic       visible_q, visible_d;

    assign wrap_o = enable_i && (count_q == tc_i);

    // Visibility is derived from the next count so it flips together with the count.
    always_comb begin
        count_d   = count_q;
        visible_d = visible_q;
        if (enable_i) begin
            count_d   = wrap_o ? 10'd0 : count_q + 10'd1;
            visible_d = (count_d < VIS_END);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= 10'd0;
            visible_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            visible_q <= visible_d;
        end
    end

    assign count_o   = count_q;
    assign visible_o = visible_q;
    assign sync_o    = (count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: 25 MHz pixel enable from CLOCK_50, X/Y counters, and
// colour/sync registers delayed one pixel period so they stay aligned at the pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    vga_timing_gen_if.master bus
);

    localparam logic [9:0] H_LAST     = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST     = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_TICK_ROW = 10'(V_VIS - 1);

    logic   div_q;
    logic   h_wrap, h_sync, v_sync, v_wrap_unused;
    logic   frame_q, frame_d;
    logic   hs_q, hs_d, vs_q, vs_d;
    color_t color_q, color_d;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) div_q <= 1'b0;
        else          div_q <= ~div_q;
    end

    vga_axis_counter #(.VIS(H_VIS), .FP(H_FP), .SYNC(H_SYNC)) u_h_axis (
        .clk_i     (CLOCK_50),
        .rst_ni    (reset_n),
        .enable_i  (div_q),
        .tc_i      (H_LAST),
        .count_o   (bus.X_pix),
        .visible_o (bus.H_visible),
        .sync_o    (h_sync),
        .wrap_o    (h_wrap)
    );

    vga_axis_counter #(.VIS(V_VIS), .FP(V_FP), .SYNC(V_SYNC)) u_v_axis (
        .clk_i     (CLOCK_50),
        .rst_ni    (reset_n),
        .enable_i  (h_wrap),
        .tc_i      (V_LAST),
        .count_o   (bus.Y_pix),
        .visible_o (bus.V_visible),
        .sync_o    (v_sync),
        .wrap_o    (v_wrap_unused)
    );

    // Colour and syncs describe the coordinate being left on this pixel edge.
    always_comb begin
        color_d = color_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        frame_d = h_wrap && (bus.Y_pix == V_TICK_ROW);
        if (div_q) begin
            color_d = (bus.H_visible && bus.V_visible) ? bus.pixel_color : '0;
            hs_d    = ~h_sync;
            vs_d    = ~v_sync;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            color_q <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            color_q <= color_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            frame_q <= frame_d;
        end
    end

    assign bus.pixel_clk  = div_q;
    assign bus.frame_tick = frame_q;
    assign bus.VGA_R      = color_q.r;
    assign bus.VGA_G      = color_q.g;
    assign bus.VGA_B      = color_q.b;
    assign bus.VGA_HS     = hs_q;
    assign bus.VGA_VS     = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced 25x11 mode; a positional
// model derived from the count of clock edges since reset checks every cycle.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HV  = 16;
    localparam int HFP = 2;
    localparam int HSY = 4;
    localparam int HBP = 3;
    localparam int HT  = HV + HFP + HSY + HBP;
    localparam int VV  = 6;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int VT  = VV + VFP + VSY + VBP;
    localparam int FT  = HT * VT;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hvis;
        logic        vvis;
        logic        pclk;
        logic        ftick;
        logic [11:0] color;
        logic        hs;
        logic        vs;
    } expect_t;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    int          passCount  = 0;
    int          checkCount = 0;
    int          edges      = 0;
    logic [11:0] sampled    = 12'h000;

    vga_timing_gen_if bus();

    vga_timing_gen #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    endtask

    // Position is (edges/2) pixels into the frame; pins show the previous pixel.
    function automatic expect_t modelAt(input int e, input logic [11:0] smp);
        int p, idx, x, y, pidx, px, py;
        expect_t r;
        p     = e / 2;
        idx   = p % FT;
        x     = idx % HT;
        y     = idx / HT;
        r.x     = 10'(x);
        r.y     = 10'(y);
        r.hvis  = (x < HV);
        r.vvis  = (y < VV);
        r.pclk  = ((e % 2) == 1);
        r.ftick = (e > 0) && ((e % 2) == 0) && (x == 0) && (y == VV);
        if (p == 0) begin
            r.color = 12'h000;
            r.hs    = 1'b1;
            r.vs    = 1'b1;
        end else begin
            pidx    = (idx + FT - 1) % FT;
            px      = pidx % HT;
            py      = pidx / HT;
            r.color = (px < HV && py < VV) ? smp : 12'h000;
            r.hs    = !(px >= HV + HFP && px <= HV + HFP + HSY - 1);
            r.vs    = !(py >= VV + VFP && py <= VV + VFP + VSY - 1);
        end
        return r;
    endfunction

    always @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            edges <= 0;
        end else begin
            edges <= edges + 1;
            if (((edges + 1) % 2) == 0) sampled <= bus.pixel_color;
        end
    end

    always @(negedge CLOCK_50) begin
        checkOutput("coords", 32'({bus.X_pix, bus.Y_pix}),
                    32'({modelAt(edges, sampled).x, modelAt(edges, sampled).y}));
        checkOutput("flags", 32'({bus.H_visible, bus.V_visible, bus.pixel_clk, bus.frame_tick}),
                    32'({modelAt(edges, sampled).hvis, modelAt(edges, sampled).vvis,
                         modelAt(edges, sampled).pclk, modelAt(edges, sampled).ftick}));
        checkOutput("colour", 32'({bus.VGA_B, bus.VGA_G, bus.VGA_R}), 32'(modelAt(edges, sampled).color));
        checkOutput("syncs", 32'({bus.VGA_HS, bus.VGA_VS}),
                    32'({modelAt(edges, sampled).hs, modelAt(edges, sampled).vs}));
    end

    task automatic waitCoord(input int x, input int y, input bit onPixel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge CLOCK_50);
            if (bus.X_pix == 10'(x) && bus.Y_pix == 10'(y) && (!onPixel || bus.pixel_clk)) ok = 1'b1;
        end
        checkOutput($sformatf("reach X=%0d Y=%0d", x, y), 32'(ok), 32'd1);
    endtask

    task automatic applyStimulus();
        bit ok;
        int gap, hsLow, vsLow, pulses;

        bus.pixel_color = 12'h000;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("reset X_pix", 32'(bus.X_pix), 32'd0);
        checkOutput("reset HS/VS", 32'({bus.VGA_HS, bus.VGA_VS}), 32'h3);
        checkOutput("reset visible", 32'({bus.H_visible, bus.V_visible}), 32'h3);
        checkOutput("reset pixel_clk", 32'(bus.pixel_clk), 32'd0);

        #2 reset_n = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("first edge pixel_clk", 32'(bus.pixel_clk), 32'd1);
        checkOutput("first edge X_pix", 32'(bus.X_pix), 32'd0);
        @(negedge CLOCK_50);
        checkOutput("first increment X_pix", 32'(bus.X_pix), 32'd1);

        bus.pixel_color = 12'hF00;
        waitCoord(HV, 1, 1'b0);
        checkOutput("last visible VGA_B", 32'(bus.VGA_B), 32'hF);
        checkOutput("last visible VGA_R/G", 32'({bus.VGA_R, bus.VGA_G}), 32'h0);
        waitCoord(HV + 1, 1, 1'b0);
        checkOutput("first blank colour", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'h0);

        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge CLOCK_50);
            if (bus.frame_tick) ok = 1'b1;
        end
        checkOutput("frame_tick seen", 32'(ok), 32'd1);
        checkOutput("frame_tick coords", 32'({bus.X_pix, bus.Y_pix}), 32'({10'd0, 10'(VV)}));
        gap = 0; hsLow = 0; vsLow = 0; pulses = 0;
        for (int i = 1; i <= 2 * FT; i++) begin
            @(negedge CLOCK_50);
            if (bus.frame_tick && gap == 0) gap = i;
            if (bus.pixel_clk) begin
                pulses++;
                if (!bus.VGA_HS) hsLow++;
                if (!bus.VGA_VS) vsLow++;
            end
        end
        checkOutput("frame period cycles", 32'(gap), 32'd550);
        checkOutput("pixel pulses per frame", 32'(pulses), 32'd275);
        checkOutput("HS low pixels per frame", 32'(hsLow), 32'd44);
        checkOutput("VS low pixels per frame", 32'(vsLow), 32'd50);

        waitCoord(HT - 1, VT - 1, 1'b1);
        @(negedge CLOCK_50);
        checkOutput("frame wrap XY", 32'({bus.X_pix, bus.Y_pix}), 32'd0);
        checkOutput("frame wrap VS", 32'(bus.VGA_VS), 32'd1);

        bus.pixel_color = 12'h000;
        waitCoord(3, 2, 1'b1);
        bus.pixel_color = 12'h5A3;
        @(negedge CLOCK_50);
        bus.pixel_color = 12'hFFF;
        @(negedge CLOCK_50);
        checkOutput("toggle sample A", 32'({bus.VGA_B, bus.VGA_G, bus.VGA_R}), 32'h5A3);
        bus.pixel_color = 12'h0C0;
        @(negedge CLOCK_50);
        bus.pixel_color = 12'h123;
        @(negedge CLOCK_50);
        checkOutput("toggle sample B", 32'({bus.VGA_B, bus.VGA_G, bus.VGA_R}), 32'h0C0);
        repeat (120) begin
            @(negedge CLOCK_50);
            bus.pixel_color = 12'($urandom);
        end

        waitCoord(10, 3, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async reset XY", 32'({bus.X_pix, bus.Y_pix}), 32'd0);
        checkOutput("async reset pclk/tick", 32'({bus.pixel_clk, bus.frame_tick}), 32'd0);
        checkOutput("async reset colour", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'd0);
        checkOutput("async reset syncs", 32'({bus.VGA_HS, bus.VGA_VS}), 32'h3);
        repeat (3) @(negedge CLOCK_50);
        #2 reset_n = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        checkOutput("restart XY", 32'({bus.X_pix, bus.Y_pix}), 32'({10'd1, 10'd0}));

        repeat (60) begin
            @(negedge CLOCK_50);
            bus.pixel_color = 12'($urandom);
        end
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
